// File: rtl/rst_pkg.sv
// ============================================================================
// rst_pkg : shared types and constants for the reset sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_e;

  typedef logic [3:0] rst_cause_t;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_SW  = 1;
  localparam int unsigned CAUSE_WDT = 2;
  localparam int unsigned CAUSE_DBG = 3;

endpackage

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// ============================================================================
// rst_seq_ctrl : ordered release of per-domain active-low resets with
//                request-driven re-sequencing and sticky reset cause
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rst_seq_ctrl
  import rst_pkg::*;
#(
  parameter int unsigned N_STAGE     = 3,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sw_rst_req_i,
  input  logic               wdt_rst_req_i,
  input  logic               dbg_rst_req_i,
  input  logic               cause_clr_i,
  output logic [N_STAGE-1:0] rstn_o,
  output logic               rst_done_o,
  output rst_cause_t         rst_cause_o
);

  localparam int unsigned c_cnt_max = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CNT_W     = $clog2(c_cnt_max + 1);
  localparam int unsigned c_idx_w   = $clog2(N_STAGE + 1);

  localparam logic [CNT_W-1:0]   c_hold_last = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   c_gap_last  = CNT_W'(STAGE_GAP - 1);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(N_STAGE - 1);

  rst_state_e           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [c_idx_w-1:0]   r_idx;
  logic [N_STAGE-1:0]   r_rstn;
  logic                 r_done;
  rst_cause_t           r_cause;

  rst_cause_t           w_set;
  logic                 w_req;

  always_comb begin
    w_set            = '0;
    w_set[CAUSE_SW]  = sw_rst_req_i;
    w_set[CAUSE_WDT] = wdt_rst_req_i;
    w_set[CAUSE_DBG] = dbg_rst_req_i;
    w_req            = |w_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rstn  <= '0;
      r_done  <= 1'b0;
      r_cause <= rst_cause_t'(1 << CAUSE_POR);
    end else begin
      // A request in the same cycle as a clear keeps its own bit; all others drop.
      if (r_state == ST_RUN && cause_clr_i)
        r_cause <= w_set;
      else
        r_cause <= r_cause | w_set;

      if (w_req) begin
        r_state <= ST_HOLD;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_rstn  <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_cnt == c_hold_last) begin
              r_cnt  <= '0;
              r_idx  <= c_idx_w'(1);
              r_rstn <= (r_rstn << 1) | N_STAGE'(1);
              if (N_STAGE == 1) begin
                r_state <= ST_RUN;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RELEASE: begin
            if (r_cnt == c_gap_last) begin
              r_cnt  <= '0;
              r_idx  <= r_idx + c_idx_w'(1);
              // Shifting a one in keeps the release a strict ascending thermometer.
              r_rstn <= (r_rstn << 1) | N_STAGE'(1);
              if (r_idx == c_idx_last) begin
                r_state <= ST_RUN;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_RUN: begin
          end
          default: begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rstn  <= '0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rstn_o      = r_rstn;
  assign rst_done_o  = r_done;
  assign rst_cause_o = r_cause;

  a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                r_cnt < CNT_W'(c_cnt_max));

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_ctrl.sv
// ============================================================================
// tb_rst_seq_ctrl : directed bench for rst_seq_ctrl, per-cycle model compare
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rst_seq_ctrl;

  localparam int N = 3;
  localparam int H = 16;
  localparam int G = 4;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rst1_n = 1'b0;
  logic       sw     = 1'b0;
  logic       wdt    = 1'b0;
  logic       dbg    = 1'b0;
  logic       clr    = 1'b0;

  logic [N-1:0] rstn;
  logic         done;
  logic [3:0]   cause;
  logic [0:0]   rstn1;
  logic         done1;
  logic [3:0]   cause1;

  int         n_chk   = 0;
  int         n_err   = 0;
  int         t       = 0;
  logic [3:0] m_cause = 4'b0001;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.N_STAGE(N), .HOLD_CYCLES(H), .STAGE_GAP(G)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .sw_rst_req_i(sw), .wdt_rst_req_i(wdt), .dbg_rst_req_i(dbg),
    .cause_clr_i(clr),
    .rstn_o(rstn), .rst_done_o(done), .rst_cause_o(cause)
  );

  rst_seq_ctrl #(.N_STAGE(1), .HOLD_CYCLES(2), .STAGE_GAP(1)) dut1 (
    .clk_i(clk), .rst_ni(rst1_n),
    .sw_rst_req_i(sw), .wdt_rst_req_i(wdt), .dbg_rst_req_i(dbg),
    .cause_clr_i(clr),
    .rstn_o(rstn1), .rst_done_o(done1), .rst_cause_o(cause1)
  );

  // t = edges since the last restart (reset or sampled request) with no request.
  function automatic logic [N-1:0] exp_rstn(input int tt);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (tt >= H + k * G);
    return r;
  endfunction

  function automatic logic exp_done(input int tt);
    return tt >= H + (N - 1) * G;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t       <= 0;
      m_cause <= 4'b0001;
    end else begin
      m_cause <= (exp_done(t) && clr) ? {dbg, wdt, sw, 1'b0}
                                      : (m_cause | {dbg, wdt, sw, 1'b0});
      t       <= (sw | wdt | dbg) ? 0 : ((t < 100000) ? t + 1 : t);
    end
  end

  always @(negedge clk) begin
    n_chk = n_chk + 1;
    if ({rstn, done, cause} !== {exp_rstn(t), exp_done(t), m_cause}) begin
      n_err = n_err + 1;
      $display("FAIL model t=%0d got rstn=%b done=%b cause=%b exp rstn=%b done=%b cause=%b",
               t, rstn, done, cause, exp_rstn(t), exp_done(t), m_cause);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Power-on reset, default sequence
    edges(5);
    check("por_rstn", 32'(rstn), 32'h0);
    check("por_done", 32'(done), 32'h0);
    check("por_cause", 32'(cause), 32'h1);
    check("por_rstn1", 32'(rstn1), 32'h0);
    rst_n = 1'b1;
    edges(15); check("e15_rstn", 32'(rstn), 32'h0);
    edges(1);  check("e16_rstn", 32'(rstn), 32'h1);
    edges(3);  check("e19_rstn", 32'(rstn), 32'h1);
    edges(1);  check("e20_rstn", 32'(rstn), 32'h3);
    edges(3);  check("e23_done", 32'(done), 32'h0);
    edges(1);  check("e24_rstn", 32'(rstn), 32'h7);
    check("e24_done", 32'(done), 32'h1);
    check("e24_cause", 32'(cause), 32'h1);

    // Watchdog pulse in RUN
    wdt = 1'b1; edges(1); wdt = 1'b0;
    check("wdt_rstn", 32'(rstn), 32'h0);
    check("wdt_done", 32'(done), 32'h0);
    check("wdt_cause", 32'(cause), 32'h5);
    edges(15); check("wdt_p16", 32'(rstn), 32'h0);
    edges(1);  check("wdt_p17", 32'(rstn), 32'h1);
    edges(8);  check("wdt_p25", 32'(rstn), 32'h7);
    check("wdt_p25_done", 32'(done), 32'h1);

    // Cause clear in RUN, clear with request, clear ignored in HOLD
    clr = 1'b1; edges(1);
    check("clr_run", 32'(cause), 32'h0);
    wdt = 1'b1; edges(1); wdt = 1'b0;
    check("clr_wdt", 32'(cause), 32'h4);
    edges(1); clr = 1'b0;
    check("clr_hold", 32'(cause), 32'h4);

    // Software request mid-release
    edges(19); check("mid_011", 32'(rstn), 32'h3);
    edges(1);
    sw = 1'b1; edges(1); sw = 1'b0;
    check("mid_rstn", 32'(rstn), 32'h0);
    check("mid_cause", 32'(cause), 32'h6);
    edges(15); check("mid_p15", 32'(rstn), 32'h0);
    edges(1);  check("mid_p16", 32'(rstn), 32'h1);
    edges(8);  check("mid_p24", 32'(rstn), 32'h7);

    // Held simultaneous debug + software request
    dbg = 1'b1; sw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      edges(1);
      check("held_rstn", 32'(rstn), 32'h0);
    end
    dbg = 1'b0; sw = 1'b0;
    check("held_cause", 32'(cause), 32'he);
    edges(23); check("held_p23", 32'(rstn), 32'h3);
    check("held_p23_done", 32'(done), 32'h0);
    edges(1);  check("held_p24", 32'(rstn), 32'h7);
    check("held_p24_done", 32'(done), 32'h1);

    // Asynchronous reset between edges while partially released
    sw = 1'b1; edges(1); sw = 1'b0;
    edges(20); check("async_pre", 32'(rstn), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rstn", 32'(rstn), 32'h0);
    check("async_done", 32'(done), 32'h0);
    check("async_cause", 32'(cause), 32'h1);

    // Single-stage, two-cycle hold instance
    @(negedge clk);
    rst1_n = 1'b1;
    edges(1);
    check("one_e1_rstn", 32'(rstn1), 32'h0);
    check("one_e1_done", 32'(done1), 32'h0);
    edges(1);
    check("one_e2_rstn", 32'(rstn1), 32'h1);
    check("one_e2_done", 32'(done1), 32'h1);
    check("one_e2_cause", 32'(cause1), 32'h1);

    edges(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer that sits directly downstream of the reset synchronizer. It consumes the synchronized active-low reset and drives a set of ordered, registered, per-domain active-low resets: core, bus/peripheral, debug-visible, and so on.
- It also re-runs the whole sequence on software, watchdog or debug reset requests, and records the cause of the last reset.

Parameters:
- N_STAGE, 3: number of sequenced reset outputs. Legal range 1..8.
- HOLD_CYCLES, 16: cycles all outputs are held low after entering HOLD. Must be ≥2.
- STAGE_GAP, 4: cycles between releases of consecutive stages. Must be ≥1.
- CNT_W, $clog2(max(HOLD_CYCLES,STAGE_GAP)+1): internal counter width. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset, driven by the synchronized reset output. Assertion is async; deassertion is already synchronous to clk_i.
- sw_rst_req_i  in  1  software reset request. Level, sampled each cycle.
- wdt_rst_req_i  in  1  watchdog reset request. Level.
- dbg_rst_req_i  in  1  debug (ndmreset) request. Level.
- cause_clr_i  in  1  clears the sticky cause bits. Honoured only in RUN.
- rstn_o  out  N_STAGE  sequenced active-low resets. Bit 0 is released first.
- rst_done_o  out  1  high when all stages are released (state RUN).
- rst_cause_o  out  4  sticky cause bits {DBG,WDT,SW,POR}.

Behaviour:
- Reset values while rst_ni=0:
  - rstn_o = all 0, rst_done_o = 0, rst_cause_o = 4'b0001 (POR), state = HOLD, counter = 0, stage index = 0.
- All outputs are flop outputs, with no combinational path from any input. This keeps rstn_o glitch-free.
- req = sw_rst_req_i | wdt_rst_req_i | dbg_rst_req_i.
- State HOLD:
  - rstn_o = 0; counter increments each cycle.
  - When counter == HOLD_CYCLES-1 and !req: rstn_o[0] <= 1, counter <= 0, stage index <= 1, go to RELEASE. If N_STAGE==1, go to RUN instead.
- State RELEASE:
  - counter increments each cycle.
  - When counter == STAGE_GAP-1: rstn_o[stage index] <= 1, counter <= 0, stage index++.
  - After the last stage is set, go to RUN. rst_done_o rises on the same edge as rstn_o[N_STAGE-1].
- State RUN:
  - rstn_o = all 1, rst_done_o = 1.
  - If req: on the next edge rstn_o <= all 0, rst_done_o <= 0, counter <= 0, stage index <= 0, go to HOLD.
- Release timing: let edge 1 be the first clk_i rising edge with rst_ni=1. rstn_o[k] is first observed high after edge HOLD_CYCLES + k*STAGE_GAP. With defaults, stages are high after edges 16, 20 and 24; rst_done_o is high after edge 24.
- req in HOLD or RELEASE:
  - All outputs go low on the next edge, counter and stage index clear, state goes to HOLD. This is a restart, not a pause.
  - A held req keeps the block in HOLD; release begins HOLD_CYCLES cycles after req drops.
- Cause bits:
  - Each cycle a request is seen, its bit is set. Simultaneous requests set all corresponding bits.
  - Bits are never cleared by a re-sequence; only by cause_clr_i in RUN, which clears all 4 bits, including POR.
  - If cause_clr_i and req occur in the same cycle, the set wins for the requested bits; the others clear.
  - cause_clr_i outside RUN is ignored.
- Monotonic release: rstn_o bits only go 0→1 in ascending index order. Any reassertion drops all bits together.
- Async reset mid-operation (any state): all outputs go to reset values immediately, with no clock required.
- Counter never wraps: it is cleared on every state transition and saturates are impossible by construction. Assertion: counter < max(HOLD_CYCLES, STAGE_GAP).

Decomposition:
- Shared package rst_pkg:
  - enum rst_state_e {ST_HOLD, ST_RELEASE, ST_RUN}.
  - Cause bit index constants: CAUSE_POR=0, CAUSE_SW=1, CAUSE_WDT=2, CAUSE_DBG=3.
  - typedef rst_cause_t = logic[3:0].
- No sub-module: a single FSM plus counter. Instantiated by the top level directly after the existing synchronizer.

Test Plan:
- POR, defaults: hold rst_ni=0 for 5 cycles, then release → rstn_o = 000 through edge 15; 001 after edge 16; 011 after edge 20; 111 and rst_done_o=1 after edge 24; rst_cause_o=0001.
- Watchdog in RUN: pulse wdt_rst_req_i for 1 cycle → rstn_o=000 and rst_done_o=0 next edge; full sequence repeats (001 at +17, 111 at +25 edges from the pulse); rst_cause_o=0101.
- Request mid-RELEASE: assert sw_rst_req_i one cycle after rstn_o=011 → rstn_o=000 next edge; HOLD restarts from 0; stage 0 releases HOLD_CYCLES edges after req drops.
- Held request plus simultaneous sources: hold dbg_rst_req_i and sw_rst_req_i high for 40 cycles → rstn_o stays 000 throughout; rst_cause_o gains bits 3 and 1; release completes 24 edges after deassertion.
- Cause clear: cause_clr_i in RUN → rst_cause_o=0000. cause_clr_i during HOLD → no change. cause_clr_i together with wdt_rst_req_i in RUN → rst_cause_o=0100.
- Async reset mid-sequence: drop rst_ni between clock edges while rstn_o=011 → rstn_o=000, rst_done_o=0 and rst_cause_o=0001 immediately; then N_STAGE=1 re-run with HOLD_CYCLES=2 → rstn_o=1 and done after edge 2.
